maze_path_checker: RTL and testbench

Downstream checker for the 15x15 maze solver. It snoops the serial maze load (`in_valid`/`maze`) into a 225-bit map, then consumes the solver's path stream (`out_valid`/`out_x`/`out_y`) and its `maze_not_valid` flag. It checks that the path is legal and emits one registered verdict per maze. The block is synthesizable and is used on-chip for self-check and in the bench as a scoreboard.

---
 rtl/maze_pkg.sv | 38 +++
 rtl/maze_step_check.sv | 51 +++++
 rtl/maze_path_checker.sv | 164 ++++++++++++++++
 tb/tb_maze_path_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
//------------------------------------------------------------------------------
// maze_pkg : shared types and constants for the maze path checker
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package maze_pkg;

   localparam int MAZE_N     = 15;
   localparam int MAZE_CELLS = MAZE_N * MAZE_N;

   typedef enum logic [2:0] {
      ERR_OK         = 3'd0,
      ERR_BAD_START  = 3'd1,
      ERR_NOT_ADJ    = 3'd2,
      ERR_WALL       = 3'd3,
      ERR_BAD_END    = 3'd4,
      ERR_OUT_RANGE  = 3'd5,
      ERR_NO_PATH    = 3'd6,
      ERR_LOAD_ABORT = 3'd7
   } chk_err_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_REPORT = 3'd4
   } chk_state_e;

   typedef struct packed {
      logic [3:0] y;
      logic [3:0] x;
   } coord_t;

endpackage

`default_nettype wire

// File: rtl/maze_step_check.sv
//------------------------------------------------------------------------------
// maze_step_check : combinational legality check of one path coordinate
// Rev 1.0         : initial release
//------------------------------------------------------------------------------
`default_nettype none

module maze_step_check
   import maze_pkg::*;
#(
   parameter int N = MAZE_N
)
(
   input  logic [3:0] i_prev_x,
   input  logic [3:0] i_prev_y,
   input  logic [3:0] i_cur_x,
   input  logic [3:0] i_cur_y,
   input  logic       i_wall,
   input  logic       i_first,
   output logic [2:0] o_err
);

   localparam logic [3:0] c_max = 4'(N - 1);

   logic signed [4:0] w_dx;
   logic signed [4:0] w_dy;
   logic        [4:0] w_adx;
   logic        [4:0] w_ady;
   logic        [5:0] w_dist;

   always_comb begin
      w_dx   = $signed({1'b0, i_cur_x}) - $signed({1'b0, i_prev_x});
      w_dy   = $signed({1'b0, i_cur_y}) - $signed({1'b0, i_prev_y});
      w_adx  = w_dx[4] ? 5'(-w_dx) : 5'(w_dx);
      w_ady  = w_dy[4] ? 5'(-w_dy) : 5'(w_dy);
      w_dist = {1'b0, w_adx} + {1'b0, w_ady};

      // Priority: out-of-range, bad start, non-adjacent, wall.
      o_err = ERR_OK;
      if (i_cur_x > c_max || i_cur_y > c_max)
         o_err = ERR_OUT_RANGE;
      else if (i_first && (i_cur_x != 4'd0 || i_cur_y != 4'd0))
         o_err = ERR_BAD_START;
      else if (!i_first && w_dist != 6'd1)
         o_err = ERR_NOT_ADJ;
      else if (i_wall)
         o_err = ERR_WALL;
   end

endmodule

`default_nettype wire

// File: rtl/maze_path_checker.sv
//------------------------------------------------------------------------------
// maze_path_checker : snoops a serial maze load, checks the solver path and
//                     issues one registered verdict per maze
// Rev 1.0           : initial release
//------------------------------------------------------------------------------
`default_nettype none

module maze_path_checker
   import maze_pkg::*;
#(
   parameter int N     = MAZE_N,
   parameter int LEN_W = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_in_valid,
   input  logic             i_maze,
   input  logic             i_out_valid,
   input  logic             i_maze_not_valid,
   input  logic [3:0]       i_out_x,
   input  logic [3:0]       i_out_y,
   output logic             o_chk_valid,
   output logic             o_chk_pass,
   output logic [2:0]       o_chk_err,
   output logic [LEN_W-1:0] o_chk_len
);

   localparam int               CELLS  = N * N;
   localparam int               CNT_W  = $clog2(CELLS + 1);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(CELLS - 1);
   localparam logic [3:0]       c_max  = 4'(N - 1);

   chk_state_e       r_state, w_state_n;
   logic [CELLS-1:0] r_map,   w_map_n;
   logic [CNT_W-1:0] r_cnt,   w_cnt_n;
   chk_err_e         r_err,   w_err_n;
   logic [LEN_W-1:0] r_len,   w_len_n;
   coord_t           r_prev,  w_prev_n;

   logic [CNT_W-1:0] w_idx;
   logic             w_in_range;
   logic             w_wall;
   logic             w_first;
   logic [2:0]       w_step_err;
   coord_t           w_cur;

   assign w_cur      = '{y: i_out_y, x: i_out_x};
   assign w_in_range = (i_out_x <= c_max) && (i_out_y <= c_max);
   assign w_idx      = CNT_W'(i_out_y) * CNT_W'(N) + CNT_W'(i_out_x);
   assign w_wall     = w_in_range ? r_map[w_idx] : 1'b0;
   assign w_first    = (r_state == ST_WAIT);

   maze_step_check #(.N(N)) u_step (
      .i_prev_x (r_prev.x),
      .i_prev_y (r_prev.y),
      .i_cur_x  (i_out_x),
      .i_cur_y  (i_out_y),
      .i_wall   (w_wall),
      .i_first  (w_first),
      .o_err    (w_step_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_map   <= '0;
         r_cnt   <= '0;
         r_err   <= ERR_OK;
         r_len   <= '0;
         r_prev  <= '0;
      end else begin
         r_state <= w_state_n;
         r_map   <= w_map_n;
         r_cnt   <= w_cnt_n;
         r_err   <= w_err_n;
         r_len   <= w_len_n;
         r_prev  <= w_prev_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_map_n   = r_map;
      w_cnt_n   = r_cnt;
      w_err_n   = r_err;
      w_len_n   = r_len;
      w_prev_n  = r_prev;

      case (r_state)
         ST_IDLE: begin
            if (i_in_valid) begin
               w_map_n[0] = i_maze;
               w_cnt_n    = CNT_W'(1);
               w_err_n    = ERR_OK;
               w_len_n    = '0;
               w_state_n  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (i_in_valid) begin
               w_map_n[r_cnt] = i_maze;
               w_cnt_n        = r_cnt + CNT_W'(1);
               if (r_cnt == c_last)
                  w_state_n = ST_WAIT;
            end else begin
               w_err_n   = ERR_LOAD_ABORT;
               w_state_n = ST_REPORT;
            end
         end
         ST_WAIT: begin
            if (i_maze_not_valid) begin
               w_err_n   = ERR_NO_PATH;
               w_state_n = ST_REPORT;
            end else if (i_out_valid) begin
               w_err_n   = chk_err_e'(w_step_err);
               w_len_n   = LEN_W'(1);
               w_prev_n  = w_cur;
               w_state_n = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (i_out_valid) begin
               // Only the first error is kept; later beats still count.
               if (r_err == ERR_OK)
                  w_err_n = chk_err_e'(w_step_err);
               w_len_n  = (&r_len) ? r_len : r_len + LEN_W'(1);
               w_prev_n = w_cur;
            end else begin
               if (r_err == ERR_OK && (r_prev.x != c_max || r_prev.y != c_max))
                  w_err_n = ERR_BAD_END;
               w_state_n = ST_REPORT;
            end
         end
         ST_REPORT: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   // Verdict registers: err/len hold between strobes, pass only during one.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_chk_valid <= 1'b0;
         o_chk_pass  <= 1'b0;
         o_chk_err   <= 3'd0;
         o_chk_len   <= '0;
      end else if (r_state == ST_REPORT) begin
         o_chk_valid <= 1'b1;
         o_chk_pass  <= (r_err == ERR_OK);
         o_chk_err   <= r_err;
         o_chk_len   <= r_len;
      end else begin
         o_chk_valid <= 1'b0;
         o_chk_pass  <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_maze_path_checker.sv
//------------------------------------------------------------------------------
// tb_maze_path_checker : directed self-checking bench for maze_path_checker
// Rev 1.0              : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_maze_path_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       maze;
   logic       out_valid;
   logic       maze_not_valid;
   logic [3:0] out_x;
   logic [3:0] out_y;
   logic       chk_valid;
   logic       chk_pass;
   logic [2:0] chk_err;
   logic [7:0] chk_len;

   int n_checks = 0;
   int n_errors = 0;

   logic [224:0] map_v;
   logic [3:0]   qx[$];
   logic [3:0]   qy[$];

   maze_path_checker #(.N(15), .LEN_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_in_valid       (in_valid),
      .i_maze           (maze),
      .i_out_valid      (out_valid),
      .i_maze_not_valid (maze_not_valid),
      .i_out_x          (out_x),
      .i_out_y          (out_y),
      .o_chk_valid      (chk_valid),
      .o_chk_pass       (chk_pass),
      .o_chk_err        (chk_err),
      .o_chk_len        (chk_len)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_maze(input int beats);
      for (int k = 0; k < beats; k++) begin
         in_valid = 1'b1;
         maze     = map_v[k];
         step();
      end
      in_valid = 1'b0;
      maze     = 1'b0;
   endtask

   task automatic push(input int x, input int y);
      qx.push_back(4'(x));
      qy.push_back(4'(y));
   endtask

   task automatic straight_path();
      qx.delete();
      qy.delete();
      for (int x = 0; x < 15; x++) push(x, 0);
      for (int y = 1; y < 15; y++) push(14, y);
   endtask

   task automatic send_path();
      for (int i = 0; i < qx.size(); i++) begin
         out_valid = 1'b1;
         out_x     = qx[i];
         out_y     = qy[i];
         step();
      end
      out_valid = 1'b0;
      out_x     = 4'd0;
      out_y     = 4'd0;
   endtask

   // Waits (bounded) for the strobe and checks the verdict fields.
   task automatic verdict(input string tag, input int exp_lat, input int pass,
                          input int err, input int len);
      int edges = 0;
      bit seen  = 0;
      while (!seen && edges < 8) begin
         step();
         edges++;
         if (chk_valid) seen = 1;
      end
      check({tag, "_seen"}, int'(seen), 1);
      if (exp_lat > 0) check({tag, "_lat"}, edges, exp_lat);
      check({tag, "_pass"}, int'(chk_pass), pass);
      check({tag, "_err"},  int'(chk_err),  err);
      check({tag, "_len"},  int'(chk_len),  len);
   endtask

   initial begin
      int strobes;
      rst = 1'b1; in_valid = 1'b0; maze = 1'b0; out_valid = 1'b0;
      maze_not_valid = 1'b0; out_x = 4'd0; out_y = 4'd0;
      step(); step();
      rst = 1'b0;
      check("rst_valid", int'(chk_valid), 0);
      check("rst_pass",  int'(chk_pass),  0);
      check("rst_err",   int'(chk_err),   0);
      check("rst_len",   int'(chk_len),   0);

      // Legal straight path on an open maze: strobe exactly 2 edges after last beat.
      map_v = '0;
      load_maze(225);
      straight_path();
      send_path();
      verdict("legal", 2, 1, 0, 29);
      step();
      check("legal_strobe_1cyc", int'(chk_valid), 0);
      check("legal_pass_low",    int'(chk_pass),  0);
      check("legal_len_hold",    int'(chk_len),   29);

      // Wall at (5,0), index 5.
      map_v = '0;
      map_v[5] = 1'b1;
      load_maze(225);
      send_path();
      verdict("wall", 2, 0, 3, 29);

      // Diagonal step, later bad end; first error kept.
      map_v = '0;
      load_maze(225);
      qx.delete(); qy.delete();
      push(0,0); push(1,0); push(2,0); push(3,0); push(4,1); push(4,2);
      send_path();
      verdict("diag", 2, 0, 2, 6);

      load_maze(225);
      qx.delete(); qy.delete();
      push(1,0); push(2,0);
      send_path();
      verdict("badstart", 2, 0, 1, 2);

      load_maze(225);
      qx.delete(); qy.delete();
      push(15,0);
      send_path();
      verdict("outrange", 2, 0, 5, 1);

      load_maze(225);
      qx.delete(); qy.delete();
      push(0,0); push(1,0);
      send_path();
      verdict("badend", 2, 0, 4, 2);

      // No path, raised together with out_valid: maze_not_valid wins.
      load_maze(225);
      maze_not_valid = 1'b1;
      out_valid      = 1'b1;
      step();
      maze_not_valid = 1'b0;
      out_valid      = 1'b0;
      verdict("nopath", 1, 0, 6, 0);

      // Load abort after 100 beats.
      load_maze(100);
      verdict("abort", 2, 0, 7, 0);

      // Reset during beat 10 of a path, then a clean maze.
      load_maze(225);
      straight_path();
      for (int i = 0; i < 9; i++) begin
         out_valid = 1'b1; out_x = qx[i]; out_y = qy[i];
         step();
      end
      out_valid = 1'b1; out_x = qx[9]; out_y = qy[9]; rst = 1'b1;
      step();
      rst = 1'b0; out_valid = 1'b0; out_x = 4'd0; out_y = 4'd0;
      check("midrst_valid", int'(chk_valid), 0);
      check("midrst_pass",  int'(chk_pass),  0);
      check("midrst_err",   int'(chk_err),   0);
      check("midrst_len",   int'(chk_len),   0);
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (chk_valid) strobes++;
      end
      check("midrst_no_verdict", strobes, 0);
      load_maze(225);
      send_path();
      verdict("after_rst", 2, 1, 0, 29);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
